// File: rtl/num_seg_driver.sv
// Binary-to-two-digit seven-segment driver for the 0..99 counter output.
// Iterative double-dabble conversion (8 shift steps) with registered segment outputs.
module num_seg_driver #(
  parameter int MAX_VAL    = 99,
  parameter bit BLANK_ZERO = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_num,
  output logic [7:0] o_seg_h,
  output logic [7:0] o_seg_l,
  output logic       o_busy,
  output logic       o_ovf
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t      state;
  logic [7:0]  last;
  logic        valid;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  step;
  logic [11:0] bcd_adj;
  logic        ovf_now;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd);
  // A nonzero hundreds digit cannot be shown on two digits, so it also forces the dash path.
  assign ovf_now = (int'(last) > MAX_VAL) || (bcd[11:8] != 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      last    <= 8'd0;
      valid   <= 1'b0;
      bin     <= 8'd0;
      bcd     <= 12'd0;
      step    <= 3'd0;
      o_seg_h <= 8'hFF;
      o_seg_l <= 8'hFF;
      o_busy  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!valid || (i_num != last)) begin
            bin    <= i_num;
            last   <= i_num;
            valid  <= 1'b1;
            bcd    <= 12'd0;
            step   <= 3'd0;
            o_busy <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd  <= {bcd_adj[10:0], bin[7]};
          bin  <= {bin[6:0], 1'b0};
          step <= step + 3'd1;
          if (step == 3'd7) state <= LOAD;
        end
        LOAD: begin
          if (ovf_now) begin
            o_seg_h <= 8'hBF;
            o_seg_l <= 8'hBF;
            o_ovf   <= 1'b1;
          end else begin
            o_ovf   <= 1'b0;
            o_seg_l <= seg_code(bcd[3:0]);
            o_seg_h <= (BLANK_ZERO && (bcd[7:4] == 4'd0)) ? 8'hFF : seg_code(bcd[7:4]);
          end
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_num_seg_driver.sv
// Scoreboard bench for num_seg_driver: default instance plus a BLANK_ZERO=1 instance.
module tb_num_seg_driver;

  typedef struct {
    logic [7:0] h;
    logic [7:0] l;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] num = 8'd0;
  logic [7:0] num_b = 8'd0;
  logic [7:0] seg_h, seg_l, seg_h_b, seg_l_b;
  logic       busy, ovf, busy_b, ovf_b;

  exp_t q[$];
  exp_t qb[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int nconv = 0;
  int last_out = 0;
  int prev_out = 0;

  num_seg_driver dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_num(num),
    .o_seg_h(seg_h), .o_seg_l(seg_l), .o_busy(busy), .o_ovf(ovf)
  );

  num_seg_driver #(.MAX_VAL(99), .BLANK_ZERO(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_num(num_b),
    .o_seg_h(seg_h_b), .o_seg_l(seg_l_b), .o_busy(busy_b), .o_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the default instance: compares when busy drops.
  initial begin
    logic pb;
    int   blen;
    exp_t e;
    pb = 1'b0;
    blen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 1'b0;
        blen = 0;
      end else begin
        if (busy) blen++;
        if (busy && !pb) nconv++;
        if (pb && !busy) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("seg_h", seg_h, e.h);
            chk("seg_l", seg_l, e.l);
            chk("ovf", ovf, e.o);
            chk("busy_len", blen, 9);
          end
          blen = 0;
          prev_out = last_out;
          last_out = cyc;
        end
        pb = busy;
      end
    end
  end

  // Monitor for the blank-zero instance.
  initial begin
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 1'b0;
      end else begin
        if (pb && !busy_b) begin
          if (qb.size() == 0) begin
            chk("b_unexpected_output", 32'd1, 32'd0);
          end else begin
            e = qb.pop_front();
            chk("b_seg_h", seg_h_b, e.h);
            chk("b_seg_l", seg_l_b, e.l);
            chk("b_ovf", ovf_b, e.o);
          end
        end
        pb = busy_b;
      end
    end
  end

  task automatic push(input logic [7:0] h, input logic [7:0] l, input logic o);
    exp_t e;
    e.h = h; e.l = l; e.o = o;
    q.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] h, input logic [7:0] l, input logic o);
    exp_t e;
    e.h = h; e.l = l; e.o = o;
    qb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || qb.size() != 0 || busy || busy_b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply(input logic [7:0] v, input logic [7:0] h, input logic [7:0] l,
                       input logic o, input int hold);
    @(negedge clk);
    num = v;
    push(h, l, o);
    wait_idle(40);
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    int n0;
    // Test 1: reset mid-conversion of 42, then release with 0.
    num = 8'd42;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_was_set", {31'd0, dut.state != 2'd0}, 32'd0);
    chk("rst_seg_h", seg_h, 8'hFF);
    chk("rst_seg_l", seg_l, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    num = 8'd0;
    push(8'hC0, 8'hC0, 1'b0);
    push_b(8'hFF, 8'hC0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(40);

    // Test 2: 42 then stable for 50 cycles.
    apply(8'd42, 8'h99, 8'hA4, 1'b0, 0);
    n0 = nconv;
    repeat (50) @(negedge clk);
    chk("stable_no_reconv", nconv, n0);
    chk("stable_busy", busy, 1'b0);
    chk("stable_seg_l", seg_l, 8'hA4);

    // Test 3: 98 -> 99 -> 0.
    apply(8'd98, 8'h90, 8'h80, 1'b0, 20);
    apply(8'd99, 8'h90, 8'h90, 1'b0, 20);
    apply(8'd0,  8'hC0, 8'hC0, 1'b0, 20);

    // Test 4: overflow then recovery.
    apply(8'd150, 8'hBF, 8'hBF, 1'b1, 5);
    apply(8'd7,   8'hC0, 8'hF8, 1'b0, 5);

    // Test 5: change 42 -> 43 during conversion.
    @(negedge clk);
    num = 8'd42;
    push(8'h99, 8'hA4, 1'b0);
    push(8'h99, 8'hB0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    num = 8'd43;
    wait_idle(60);
    chk("requeue_gap", last_out - prev_out, 10);

    // Test 6: blank-zero instance.
    @(negedge clk);
    num_b = 8'd7;
    push_b(8'hFF, 8'hF8, 1'b0);
    wait_idle(40);
    @(negedge clk);
    num_b = 8'd10;
    push_b(8'hF9, 8'hC0, 1'b0);
    wait_idle(40);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
